// File: rtl/usb_transmitter.sv
// USB full-speed packet transmitter: SYNC, PID, FIFO payload and EOP.
// The line is NRZI-coded with bit stuffing, LSB first, and each bit is held CLKS_PER_BIT clocks.
//
// state      | meaning
// IDLE       | line at J, waiting for tx_start
// LOAD       | request accepted, first SYNC bit goes out on the next edge
// SYNC       | shifting out 8'h80
// PID        | shifting out {~pid,pid}
// DATA       | shifting out payload bytes popped from the FIFO
// EOP_SE0    | both lines low for EOP_SE0_BITS bit periods
// EOP_J      | one bit period of J, then tx_done
module usb_transmitter #(
  parameter int CLKS_PER_BIT = 8,
  parameter int EOP_SE0_BITS = 2,
  parameter int MAX_BYTES    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic [6:0] tx_num_bytes,
  input  logic [7:0] tx_data,
  input  logic       fifo_empty,
  output logic       get_tx_data,
  output logic       d_plus_out,
  output logic       d_minus_out,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_SYNC    = 3'd2;
  localparam logic [2:0] ST_PID     = 3'd3;
  localparam logic [2:0] ST_DATA    = 3'd4;
  localparam logic [2:0] ST_EOP_SE0 = 3'd5;
  localparam logic [2:0] ST_EOP_J   = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bits_left_q, bits_left_d;
  logic [2:0]    ones_q, ones_d;
  logic [6:0]    byte_cnt_q, byte_cnt_d;
  logic [3:0]    pid_q, pid_d;
  logic          line_q, line_d;
  logic          se0_q, se0_d;
  logic          pop_q, pop_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic       boundary;
  logic       emit_v;
  logic       bit_v;
  logic       enter_eop;
  logic [7:0] pid_byte;

  assign boundary = (timer_q == '0);
  assign pid_byte = {~pid_q, pid_q};

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    shift_d     = shift_q;
    bits_left_d = bits_left_q;
    ones_d      = ones_q;
    byte_cnt_d  = byte_cnt_q;
    pid_d       = pid_q;
    line_d      = line_q;
    se0_d       = se0_q;
    pop_d       = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    emit_v      = 1'b0;
    bit_v       = 1'b0;
    enter_eop   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          state_d    = ST_LOAD;
          pid_d      = tx_pid;
          byte_cnt_d = (tx_num_bytes > 7'(MAX_BYTES)) ? 7'(MAX_BYTES) : tx_num_bytes;
          error_d    = 1'b0;
        end
      end
      ST_LOAD: begin
        state_d     = ST_SYNC;
        busy_d      = 1'b1;
        timer_d     = TMAX;
        ones_d      = '0;
        emit_v      = 1'b1;
        bit_v       = 1'b0;
        shift_d     = 8'h40;
        bits_left_d = 3'd7;
      end
      ST_SYNC, ST_PID, ST_DATA: begin
        if (boundary) begin
          timer_d = TMAX;
          // A pending stuff bit takes priority over both the next data bit and EOP.
          if (ones_q == 3'd6) begin
            emit_v = 1'b1;
            bit_v  = 1'b0;
          end else if (bits_left_q != '0) begin
            emit_v      = 1'b1;
            bit_v       = shift_q[0];
            shift_d     = {1'b0, shift_q[7:1]};
            bits_left_d = bits_left_q - 3'd1;
          end else if (state_q == ST_SYNC) begin
            state_d     = ST_PID;
            emit_v      = 1'b1;
            bit_v       = pid_byte[0];
            shift_d     = {1'b0, pid_byte[7:1]};
            bits_left_d = 3'd7;
          end else if (byte_cnt_q == '0) begin
            enter_eop = 1'b1;
          end else if (fifo_empty) begin
            error_d   = 1'b1;
            enter_eop = 1'b1;
          end else begin
            state_d     = ST_DATA;
            emit_v      = 1'b1;
            bit_v       = tx_data[0];
            shift_d     = {1'b0, tx_data[7:1]};
            bits_left_d = 3'd7;
            byte_cnt_d  = byte_cnt_q - 7'd1;
            pop_d       = 1'b1;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_EOP_SE0: begin
        if (boundary) begin
          timer_d = TMAX;
          if (bits_left_q != '0) begin
            bits_left_d = bits_left_q - 3'd1;
          end else begin
            state_d = ST_EOP_J;
            se0_d   = 1'b0;
            line_d  = 1'b1;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_EOP_J: begin
        if (boundary) begin
          state_d = ST_IDLE;
          timer_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        line_d  = 1'b1;
        se0_d   = 1'b0;
        busy_d  = 1'b0;
        timer_d = '0;
      end
    endcase

    // NRZI: a zero toggles the line, a one holds it and extends the run of ones.
    if (emit_v) begin
      if (!bit_v) begin
        line_d = ~line_q;
        ones_d = '0;
      end else begin
        ones_d = ones_q + 3'd1;
      end
    end

    if (enter_eop) begin
      state_d     = ST_EOP_SE0;
      se0_d       = 1'b1;
      bits_left_d = 3'(EOP_SE0_BITS - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      shift_q     <= '0;
      bits_left_q <= '0;
      ones_q      <= '0;
      byte_cnt_q  <= '0;
      pid_q       <= '0;
      line_q      <= 1'b1;
      se0_q       <= 1'b0;
      pop_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      shift_q     <= shift_d;
      bits_left_q <= bits_left_d;
      ones_q      <= ones_d;
      byte_cnt_q  <= byte_cnt_d;
      pid_q       <= pid_d;
      line_q      <= line_d;
      se0_q       <= se0_d;
      pop_q       <= pop_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign d_plus_out  = line_q & ~se0_q;
  assign d_minus_out = ~line_q & ~se0_q;
  assign get_tx_data = pop_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;

endmodule

// File: tb/tb_usb_transmitter.sv
// Bench for usb_transmitter: a bit-stream model (raw bits -> stuffing -> NRZI -> EOP)
// predicts every line cycle, and a negedge compare process checks the DUT against it.
module tb_usb_transmitter;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [3:0] tx_pid;
  logic [6:0] tx_num_bytes;
  logic [7:0] tx_data;
  logic       fifo_empty;
  logic       get_tx_data;
  logic       d_plus_out;
  logic       d_minus_out;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  always #5 clk = ~clk;

  usb_transmitter dut (
    .clk          (clk),
    .rst          (rst),
    .tx_start     (tx_start),
    .tx_pid       (tx_pid),
    .tx_num_bytes (tx_num_bytes),
    .tx_data      (tx_data),
    .fifo_empty   (fifo_empty),
    .get_tx_data  (get_tx_data),
    .d_plus_out   (d_plus_out),
    .d_minus_out  (d_minus_out),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .tx_error     (tx_error)
  );

  logic [7:0] fifo_mem [0:255];
  int rd_p = 0;
  int wr_p = 0;
  assign fifo_empty = (rd_p == wr_p);
  assign tx_data    = fifo_mem[rd_p[7:0]];

  always @(posedge clk) if (get_tx_data && (rd_p != wr_p)) rd_p <= rd_p + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  logic exp_dp  [0:8191];
  logic exp_dm  [0:8191];
  logic exp_pop [0:8191];
  int   exp_len;
  int   exp_stuffs;
  logic exp_err;

  // Expected waveform from the protocol rules, one entry per clock.
  task automatic build_model(input logic [3:0] pid, input int cnt, input int avail);
    logic rb[$];
    bit   mark[$];
    logic sb[$];
    bit   sflag[$];
    logic [7:0] byte_v;
    int c, ns, ones, idx;
    logic lvl;
    c  = (cnt > 64) ? 64 : cnt;
    ns = (c < avail) ? c : avail;
    exp_err = (avail < c);
    byte_v = 8'h80;
    for (int i = 0; i < 8; i++) begin rb.push_back(byte_v[i]); mark.push_back(0); end
    byte_v = {~pid, pid};
    for (int i = 0; i < 8; i++) begin rb.push_back(byte_v[i]); mark.push_back(0); end
    for (int k = 0; k < ns; k++) begin
      byte_v = fifo_mem[k];
      for (int i = 0; i < 8; i++) begin rb.push_back(byte_v[i]); mark.push_back(i == 0); end
    end
    ones = 0;
    for (int j = 0; j < rb.size(); j++) begin
      sb.push_back(rb[j]);
      sflag.push_back(mark[j]);
      ones = rb[j] ? ones + 1 : 0;
      if (ones == 6) begin sb.push_back(1'b0); sflag.push_back(0); ones = 0; end
    end
    exp_stuffs = sb.size() - rb.size();
    lvl = 1'b1;
    idx = 0;
    for (int j = 0; j < sb.size(); j++) begin
      if (!sb[j]) lvl = ~lvl;
      for (int t = 0; t < CPB; t++) begin
        exp_dp[idx] = lvl; exp_dm[idx] = ~lvl; exp_pop[idx] = (t == 0) && sflag[j]; idx++;
      end
    end
    for (int t = 0; t < 2 * CPB; t++) begin
      exp_dp[idx] = 1'b0; exp_dm[idx] = 1'b0; exp_pop[idx] = 1'b0; idx++;
    end
    for (int t = 0; t < CPB; t++) begin
      exp_dp[idx] = 1'b1; exp_dm[idx] = 1'b0; exp_pop[idx] = 1'b0; idx++;
    end
    exp_len = idx;
  endtask

  logic armed = 1'b0;
  int   cidx  = 0;

  always @(negedge clk) begin
    if (armed) begin
      if (cidx < exp_len) begin
        chk("d_plus", d_plus_out, exp_dp[cidx]);
        chk("d_minus", d_minus_out, exp_dm[cidx]);
        chk("busy", tx_busy, 1);
        chk("done_early", tx_done, 0);
        chk("pop", get_tx_data, exp_pop[cidx]);
      end else begin
        chk("done", tx_done, 1);
        chk("busy_at_done", tx_busy, 0);
        chk("j_at_done", {d_plus_out, d_minus_out}, 2'b10);
        chk("error_at_done", tx_error, exp_err);
        armed = 1'b0;
      end
      cidx++;
    end
  end

  task automatic fill_fifo(input int n, input int mode, input logic [7:0] b0);
    for (int k = 0; k < n; k++) begin
      if (mode == 0) fifo_mem[k] = b0;
      else fifo_mem[k] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
    end
    rd_p = 0;
    wr_p = n;
  endtask

  task automatic start_packet(input logic [3:0] pid, input int cnt);
    @(negedge clk);
    #1;
    tx_start = 1'b1;
    tx_pid = pid;
    tx_num_bytes = 7'(cnt);
    @(negedge clk);
    chk("pre_busy", tx_busy, 0);
    chk("pre_j", {d_plus_out, d_minus_out}, 2'b10);
    chk("err_cleared", tx_error, 0);
    #1;
    tx_start = 1'b0;
    cidx = 0;
    armed = 1'b1;
  endtask

  task automatic wait_packet(input bit retrig);
    int t;
    t = 0;
    while (armed && t < exp_len + 50) begin
      @(negedge clk);
      #1;
      t++;
      if (retrig) begin
        tx_start = (t == 20);
        tx_pid = 4'b1001;
        tx_num_bytes = 7'd5;
      end
    end
    tx_start = 1'b0;
    if (armed) begin
      chk("packet_timeout", 0, 1);
      armed = 1'b0;
    end
  endtask

  task automatic run_packet(input logic [3:0] pid, input int cnt, input bit retrig);
    build_model(pid, cnt, wr_p);
    start_packet(pid, cnt);
    wait_packet(retrig);
  endtask

  initial begin
    int cnt, fill;
    bit seen_done;
    rst = 1'b1;
    tx_start = 1'b0;
    tx_pid = '0;
    tx_num_bytes = '0;
    for (int k = 0; k < 256; k++) fifo_mem[k] = '0;
    repeat (3) @(negedge clk);
    chk("rst_lines", {d_plus_out, d_minus_out}, 2'b10);
    chk("rst_flags", {get_tx_data, tx_busy, tx_done, tx_error}, 4'b0000);
    #1;
    rst = 1'b0;

    // ACK
    fill_fifo(0, 0, 8'h00);
    build_model(4'b0010, 0, 0);
    chk("ack_len", exp_len, 152);
    chk("ack_first_bit_k", {exp_dp[0], exp_dm[0]}, 2'b01);
    chk("ack_sync_last_k", {exp_dp[7 * CPB], exp_dp[6 * CPB]}, 2'b00);
    run_packet(4'b0010, 0, 0);

    // DATA0 0x55
    fill_fifo(1, 0, 8'h55);
    build_model(4'b0011, 1, 1);
    chk("d55_len", exp_len, 216);
    chk("d55_stuffs", exp_stuffs, 0);
    run_packet(4'b0011, 1, 0);
    chk("d55_fifo_drained", rd_p, 1);

    // DATA0 0xFF: stuff after the 4th one of the payload
    fill_fifo(1, 0, 8'hFF);
    build_model(4'b0011, 1, 1);
    chk("dff_len", exp_len, 224);
    chk("dff_stuffs", exp_stuffs, 1);
    run_packet(4'b0011, 1, 0);

    // underflow: two requested, one available
    fill_fifo(1, 0, 8'hA7);
    build_model(4'b0011, 2, 1);
    chk("uf_expect_err", exp_err, 1);
    run_packet(4'b0011, 2, 0);
    repeat (5) @(negedge clk);
    chk("uf_err_sticky", tx_error, 1);

    // reset mid-DATA
    fill_fifo(3, 1, 8'h00);
    build_model(4'b1011, 3, 3);
    start_packet(4'b1011, 3);
    repeat (200) @(negedge clk);
    #1;
    armed = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_lines", {d_plus_out, d_minus_out}, 2'b10);
    chk("rst_mid_busy", tx_busy, 0);
    chk("rst_mid_done", tx_done, 0);
    #1;
    rst = 1'b0;
    seen_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_done) seen_done = 1;
    end
    chk("rst_no_done", seen_done, 0);
    fill_fifo(0, 0, 8'h00);
    run_packet(4'b0010, 0, 0);

    // clamp: 70 requested, only 64 go out
    fill_fifo(70, 1, 8'h00);
    run_packet(4'b1100, 70, 0);
    chk("clamp_pops", rd_p, 64);

    // randomized packets, some retriggered while busy, some underflowing
    for (int it = 0; it < 14; it++) begin
      cnt = $urandom_range(0, 10);
      fill = ($urandom_range(0, 4) == 0) ? $urandom_range(0, cnt) : cnt;
      fill_fifo(fill, 1, 8'h00);
      run_packet(4'($urandom), cnt, (it % 4) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
